// File: rtl/fp_mult_arbiter.sv
// Round-robin sharing of one pipelined FP32 multiplier between NUM_REQ clients.
// A tag pipe tracks ownership of in-flight ops and steers results to per-client buffers.
module fp_mult_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = 2,
    localparam int TAG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [NUM_REQ*32-1:0]  resp_result,
    output logic [NUM_REQ*3-1:0]   resp_flags,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    input  logic [31:0]            mul_result,
    input  logic                   mul_exception,
    input  logic                   mul_overflow,
    input  logic                   mul_underflow,
    output logic                   busy
);

    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [TAG_W-1:0]   grant_idx;

    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]   pipe_tag_q [LATENCY];
    logic [TAG_W-1:0]   pipe_tag_d [LATENCY];

    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]        result_q [NUM_REQ];
    logic [31:0]        result_d [NUM_REQ];
    logic [2:0]         flags_q  [NUM_REQ];
    logic [2:0]         flags_d  [NUM_REQ];

    logic               cap_vld;
    logic [TAG_W-1:0]   cap_tag;
    logic [NUM_REQ-1:0] resp_hs;

    assign elig    = req_valid & ~pending_q;
    assign resp_hs = resp_valid_q & resp_ready;
    assign cap_vld = pipe_vld_q[LATENCY-1];
    assign cap_tag = pipe_tag_q[LATENCY-1];

    // Scan from rr_ptr upward, wrapping, and take the first eligible client
    always_comb begin
        int idx;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && elig[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = TAG_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            if (grant_idx == TAG_W'(NUM_REQ - 1)) rr_ptr_d = '0;
            else                                 rr_ptr_d = grant_idx + 1'b1;
        end
    end

    always_comb begin
        pending_d = (pending_q | grant) & ~resp_hs;
    end

    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_vld_d[0] = grant_any;
        for (int k = 0; k < LATENCY; k++) pipe_tag_d[k] = pipe_tag_q[k];
        pipe_tag_d[0] = grant_idx;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_tag_d[k] = pipe_tag_q[k-1];
        end
    end

    // Data is only written on capture, so it stays put after the client accepts
    always_comb begin
        resp_valid_d = resp_valid_q & ~resp_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            result_d[i] = result_q[i];
            flags_d[i]  = flags_q[i];
        end
        if (cap_vld) begin
            resp_valid_d[cap_tag] = 1'b1;
            result_d[cap_tag]     = mul_result;
            flags_d[cap_tag]      = {mul_exception, mul_overflow, mul_underflow};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            pipe_vld_q   <= '0;
            resp_valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) pipe_tag_q[k] <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                result_q[i] <= '0;
                flags_q[i]  <= '0;
            end
        end else begin
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            pipe_vld_q   <= pipe_vld_d;
            resp_valid_q <= resp_valid_d;
            for (int k = 0; k < LATENCY; k++) pipe_tag_q[k] <= pipe_tag_d[k];
            for (int i = 0; i < NUM_REQ; i++) begin
                result_q[i] <= result_d[i];
                flags_q[i]  <= flags_d[i];
            end
        end
    end

    always_comb begin
        req_ready = grant;
        mul_a     = '0;
        mul_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_a = req_a[32*i +: 32];
                mul_b = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        resp_valid = resp_valid_q;
        busy       = |pending_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_result[32*i +: 32] = result_q[i];
            resp_flags[3*i +: 3]    = flags_q[i];
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: mock pipelined FP32 multiplier plus an
// ownership/latency reference model, directed cases then random traffic.
module tb_fp_mult_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [N*32-1:0] resp_result;
    logic [N*3-1:0]  resp_flags;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_result;
    logic            mul_exception;
    logic            mul_overflow;
    logic            mul_underflow;
    logic            busy;

    fp_mult_arbiter #(.NUM_REQ(N), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_exception(mul_exception),
        .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // FP32 multiply, denormals flushed, truncating; returns {flags, result}
    function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] p;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {3'b100, 32'h7FC00000};
        if (ea == 0 || eb == 0) return {3'b000, s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = ea + eb - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0) return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], m};
    endfunction

    logic [31:0] mi_a, mi_b;
    always_ff @(posedge clk) begin
        if (reset) begin
            mi_a <= '0;
            mi_b <= '0;
            {mul_exception, mul_overflow, mul_underflow, mul_result} <= '0;
        end else begin
            mi_a <= mul_a;
            mi_b <= mul_b;
            {mul_exception, mul_overflow, mul_underflow, mul_result} <= fmul(mi_a, mi_b);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-client outstanding op with the cycle it becomes visible
    int          cyc;
    int          m_ptr;
    bit          m_pend [N];
    int          m_due  [N];
    logic [31:0] m_res  [N];
    logic [2:0]  m_flg  [N];

    task automatic model_clear();
        cyc   = 0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge
    task automatic step();
        int          g;
        int          idx;
        bit          any;
        logic [N-1:0] rv;
        logic [34:0] fr;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx] && !m_pend[idx]) g = idx;
        end
        check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
        check("mul_a", 64'(mul_a), (g >= 0) ? 64'(req_a[32*g +: 32]) : 64'(0));
        check("mul_b", 64'(mul_b), (g >= 0) ? 64'(req_b[32*g +: 32]) : 64'(0));
        any = 1'b0;
        for (int i = 0; i < N; i++) any |= m_pend[i];
        check("busy", 64'(busy), 64'(any));
        for (int i = 0; i < N; i++) begin
            rv[i] = m_pend[i] && (cyc >= m_due[i]);
            check($sformatf("resp_valid%0d", i), 64'(resp_valid[i]), 64'(rv[i]));
            if (rv[i]) begin
                check($sformatf("resp_result%0d", i), 64'(resp_result[32*i +: 32]), 64'(m_res[i]));
                check($sformatf("resp_flags%0d", i), 64'(resp_flags[3*i +: 3]), 64'(m_flg[i]));
            end
        end
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (rv[i] && resp_ready[i]) m_pend[i] = 1'b0;
        if (g >= 0) begin
            fr        = fmul(req_a[32*g +: 32], req_b[32*g +: 32]);
            m_pend[g] = 1'b1;
            m_due[g]  = cyc + 3;
            m_res[g]  = fr[31:0];
            m_flg[g]  = fr[34:32];
            m_ptr     = (g + 1) % N;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [31:0] ra, rb;
        req_a = '0;
        req_b = '0;
        do_reset();

        // reset state
        #1;
        check("rst_result", 64'(resp_result), 64'(0));
        check("rst_flags", 64'(resp_flags), 64'(0));
        check("rst_valid", 64'(resp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        idle(1);

        // single op
        model_clear();
        resp_ready = '1;
        set_op(0, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        #1 check("single_grant", 64'(req_ready), 64'(4'b0001));
        step();
        idle(2);
        #1;
        check("single_valid", 64'(resp_valid[0]), 64'(1));
        check("single_res", 64'(resp_result[31:0]), 64'(32'h40C00000));
        check("single_flg", 64'(resp_flags[2:0]), 64'(0));
        step();
        idle(1);
        #1 check("single_busy", 64'(busy), 64'(0));
        idle(1);

        // round robin
        do_reset();
        resp_ready = '1;
        for (int i = 0; i < N; i++) set_op(i, 32'h3FC00000, 32'h3FC00000);
        req_valid = '1;
        for (int k = 0; k < N; k++) begin
            #1 check($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(1) << k);
            step();
        end
        req_valid = '0;
        idle(2);
        #1 check("rr_res3", 64'(resp_result[127:96]), 64'(32'h40100000));
        idle(3);

        // backpressure on req1 while req0 keeps being served
        resp_ready = 4'b1101;
        set_op(1, 32'h40000000, 32'h40400000);
        set_op(0, 32'h3F800000, 32'h40800000);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0011;
        for (int k = 0; k < 10; k++) step();
        #1;
        check("bp_valid", 64'(resp_valid[1]), 64'(1));
        check("bp_res", 64'(resp_result[63:32]), 64'(32'h40C00000));
        resp_ready = 4'b1111;
        step();
        #1 check("bp_regrant", 64'(req_ready[1]), 64'(1));
        step();
        idle(5);

        // overflow flag
        resp_ready = 4'b1011;
        set_op(2, 32'h7F000000, 32'h7F000000);
        req_valid = 4'b0100;
        step();
        idle(4);
        #1;
        check("ovf_res", 64'(resp_result[95:64]), 64'(32'h7F800000));
        check("ovf_flg", 64'(resp_flags[8:6]), 64'(3'b010));
        resp_ready = '1;
        idle(2);

        // reset with ops in flight
        do_reset();
        resp_ready = '1;
        req_valid = 4'b0011;
        step();
        step();
        do_reset();
        resp_ready = '1;
        idle(6);
        #1 check("rst_no_resp", 64'(resp_valid), 64'(0));
        req_valid = 4'b1001;
        #1 check("rst_ptr", 64'(req_ready), 64'(4'b0001));
        step();
        idle(6);

        // pointer wrap
        do_reset();
        resp_ready = '1;
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1001;
        #1 check("wrap_g3", 64'(req_ready), 64'(4'b1000));
        step();
        #1 check("wrap_g0", 64'(req_ready), 64'(4'b0001));
        step();
        idle(6);

        // random traffic
        for (int k = 0; k < 800; k++) begin
            req_valid  = N'($urandom);
            resp_ready = N'($urandom) | N'($urandom);
            for (int i = 0; i < N; i++) begin
                ra = $urandom;
                rb = $urandom;
                if ($urandom_range(3) != 0) begin
                    ra[30:23] = 8'($urandom_range(160, 100));
                    rb[30:23] = 8'($urandom_range(160, 100));
                end
                set_op(i, ra, rb);
            end
            if (k == 400) begin
                do_reset();
            end else begin
                step();
            end
        end
        resp_ready = '1;
        idle(8);
        #1 check("drain_busy", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
